// File: rtl/bridge_pkg.sv
// ---------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the AHB-to-APB bridge slave side:
//   - address windows of the three APB slaves behind the bridge
//   - HTRANS / HRESP / HSIZE encodings
//   - state type of the error-response FSM
// ---------------------------------------------------------------------------
package bridge_pkg;

    // Each slave owns a 64 MiB window starting at 0x8000_0000.
    localparam logic [31:0] SLAVE0_BASE = 32'h8000_0000;
    localparam logic [31:0] SLAVE0_LAST = 32'h83FF_FFFF;
    localparam logic [31:0] SLAVE1_BASE = 32'h8400_0000;
    localparam logic [31:0] SLAVE1_LAST = 32'h87FF_FFFF;
    localparam logic [31:0] SLAVE2_BASE = 32'h8800_0000;
    localparam logic [31:0] SLAVE2_LAST = 32'h8BFF_FFFF;

    // One-hot slave selects; all-zero means the address is unmapped.
    localparam logic [2:0] SEL_NONE   = 3'b000;
    localparam logic [2:0] SEL_SLAVE0 = 3'b001;
    localparam logic [2:0] SEL_SLAVE1 = 3'b010;
    localparam logic [2:0] SEL_SLAVE2 = 3'b100;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Largest legal transfer size (word).
    localparam logic [2:0] HSIZE_MAX = 3'b010;

    // Two-cycle AHB error response: ERR1 stalls, ERR2 completes.
    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_ONE  = 2'b01,
        ERR_TWO  = 2'b10
    } err_state_t;

endpackage : bridge_pkg

// File: rtl/ahb_addr_decode.sv
// ---------------------------------------------------------------------------
// ahb_addr_decode
// Combinational address decoder producing a one-hot APB slave select.
// Ports:
//   addr  in  32  AHB address-phase address
//   sel   out 3   one-hot slave select (000 = unmapped)
// ---------------------------------------------------------------------------
module ahb_addr_decode
    import bridge_pkg::*;
(
    input  logic [31:0] addr,
    output logic [2:0]  sel
);

    // Full-range compares so that every address bit takes part in the decode.
    always_comb begin
        sel = SEL_NONE;
        if (addr >= SLAVE0_BASE && addr <= SLAVE0_LAST) begin
            sel = SEL_SLAVE0;
        end else if (addr >= SLAVE1_BASE && addr <= SLAVE1_LAST) begin
            sel = SEL_SLAVE1;
        end else if (addr >= SLAVE2_BASE && addr <= SLAVE2_LAST) begin
            sel = SEL_SLAVE2;
        end
    end

endmodule : ahb_addr_decode

// File: rtl/ahb_slave_interface.sv
// ---------------------------------------------------------------------------
// ahb_slave_interface
// AHB slave front end of an AHB-to-APB bridge. Qualifies AHB transfers,
// pipelines address/write data for the APB controller and generates the
// two-cycle ERROR response for unmapped or oversized transfers.
// Ports:
//   HCLK       in  1   clock, rising edge
//   HRESETn    in  1   synchronous reset, active HIGH despite the name
//   HADDR      in  32  address-phase address
//   HWDATA     in  32  write data
//   HTRANS     in  2   transfer type
//   HWRITE     in  1   1 = write
//   HSIZE      in  3   transfer size (> 3'b010 is illegal)
//   HREADYin   in  1   AHB bus ready
//   HREADOUT   in  1   ready from the APB FSM controller
//   PRDATA     in  32  APB read data
//   VALID      out 1   accepted, mapped transfer this cycle
//   HADDR0/1   out 32  address pipeline (0 newest)
//   HWDATA0/1  out 32  write-data pipeline (0 newest)
//   HWRITEREG  out 1   registered HWRITE
//   TEMP       out 3   one-hot slave select
//   HREADYout  out 1   ready returned to the master
//   HRESP      out 2   transfer response
//   HRDATA     out 32  read data returned to the master
// ---------------------------------------------------------------------------
module ahb_slave_interface
    import bridge_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADYin,
    input  logic        HREADOUT,
    input  logic [31:0] PRDATA,
    output logic        VALID,
    output logic [31:0] HADDR0,
    output logic [31:0] HADDR1,
    output logic [31:0] HWDATA0,
    output logic [31:0] HWDATA1,
    output logic        HWRITEREG,
    output logic [2:0]  TEMP,
    output logic        HREADYout,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    err_state_t err_state;
    logic       active;
    logic       bad_xfer;

    ahb_addr_decode u_addr_decode (
        .addr (HADDR),
        .sel  (TEMP)
    );

    // IDLE and BUSY never count as transfers, nor does anything while the bus stalls.
    assign active   = HREADYin && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign bad_xfer = (TEMP == SEL_NONE) || (HSIZE > HSIZE_MAX);

    // Transfers arriving during an error response are dropped; reset masks HTRANS.
    assign VALID = !HRESETn && active && !bad_xfer && (err_state == ERR_OK);

    assign HRDATA = PRDATA;

    // Address/data pipeline advances only when the bus is ready.
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            HADDR0    <= '0;
            HADDR1    <= '0;
            HWDATA0   <= '0;
            HWDATA1   <= '0;
            HWRITEREG <= 1'b0;
        end else if (HREADYin) begin
            HADDR1    <= HADDR0;
            HADDR0    <= HADDR;
            HWDATA1   <= HWDATA0;
            HWDATA0   <= HWDATA;
            HWRITEREG <= HWRITE;
        end
    end

    // Error FSM: a bad transfer starts a fixed two-cycle ERROR response.
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            err_state <= ERR_OK;
        end else begin
            case (err_state)
                ERR_OK:  if (active && bad_xfer) err_state <= ERR_ONE;
                ERR_ONE: err_state <= ERR_TWO;
                ERR_TWO: err_state <= ERR_OK;
                default: err_state <= ERR_OK;
            endcase
        end
    end

    // Response decode; reset forces OKAY so an in-flight error is aborted at once.
    always_comb begin
        HRESP     = HRESP_OKAY;
        HREADYout = HREADOUT;
        if (!HRESETn) begin
            case (err_state)
                ERR_ONE: begin
                    HRESP     = HRESP_ERROR;
                    HREADYout = 1'b0;
                end
                ERR_TWO: begin
                    HRESP     = HRESP_ERROR;
                    HREADYout = 1'b1;
                end
                default: begin
                    HRESP     = HRESP_OKAY;
                    HREADYout = HREADOUT;
                end
            endcase
        end
    end

endmodule : ahb_slave_interface

// File: doc/ahb_slave_interface.md
AHB_SLAVE_INTERFACE -- requirements
Module: ahb_slave_interface

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 HCLK  in  1  bridge clock; all state updates on its rising edge.
REQ-003 HRESETn  in  1  synchronous reset, active-high; the port name is fixed, the polarity is high.
REQ-004 HADDR  in  32  AHB address-phase address.
REQ-005 HWDATA  in  32  AHB data-phase write data.
REQ-006 HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 HWRITE  in  1  1 means write.
REQ-008 HSIZE  in  3  transfer size; sizes above 3'b010 are illegal.
REQ-009 HREADYin  in  1  AHB bus ready.
REQ-010 HREADOUT  in  1  ready from the downstream APB FSM controller.
REQ-011 PRDATA  in  32  APB read data.
REQ-012 VALID  out  1  accepted, mapped transfer this cycle.
REQ-013 HADDR0, HADDR1  out  32 each  address pipeline (stage 0 newest).
REQ-014 HWDATA0, HWDATA1  out  32 each  write-data pipeline.
REQ-015 HWRITEREG  out  1  registered HWRITE.
REQ-016 TEMP  out  3  one-hot slave select, decoded from HADDR.
REQ-017 HREADYout  out  1  AHB ready returned to the master.
REQ-018 HRESP  out  2  00 OKAY, 01 ERROR.
REQ-019 HRDATA  out  32  read data returned to the master.

Function
REQ-020 TEMP SHALL be decoded combinationally from HADDR:
- 0x8000_0000–0x83FF_FFFF gives 3'b001.
- 0x8400_0000–0x87FF_FFFF gives 3'b010.
- 0x8800_0000–0x8BFF_FFFF gives 3'b100.
- Any other address gives 3'b000 (unmapped).
REQ-021 A transfer SHALL be "active" when HREADYin=1 and HTRANS[1]=1; IDLE and BUSY are never active.
REQ-022 VALID SHALL be 1 (combinationally) only when all of the following hold: the transfer is active, TEMP≠0, HSIZE≤3'b010, and the error FSM is in OK.
REQ-023 When HREADYin=1, each rising edge SHALL perform one pipeline shift:
- HADDR1←HADDR0 and HADDR0←HADDR.
- HWDATA1←HWDATA0 and HWDATA0←HWDATA.
- HWRITEREG←HWRITE.
REQ-024 When HREADYin=0, all pipeline registers SHALL hold; the latency from address phase to HADDR0 is therefore 1 cycle.
REQ-025 The error FSM SHALL have three states: OK, ERR1 and ERR2.
REQ-026 Error FSM transitions SHALL be:
- OK→ERR1 when the transfer is active and (TEMP=0 or HSIZE>3'b010).
- ERR1→ERR2 unconditionally.
- ERR2→OK unconditionally.
REQ-027 Error FSM outputs SHALL be:
- OK: HRESP=00 and HREADYout=HREADOUT.
- ERR1: HRESP=01 and HREADYout=0.
- ERR2: HRESP=01 and HREADYout=1.
REQ-028 A transfer presented while the FSM is in ERR1 or ERR2 SHALL be ignored: VALID=0, no new error is raised, and the pipeline shift still follows HREADYin.
REQ-029 HRDATA SHALL equal PRDATA combinationally in every state.
REQ-030 Back-to-back mapped transfers SHALL assert VALID on every accepting cycle with no bubble inserted.

Reset
REQ-031 While HRESETn=1 at a clock edge, the following SHALL clear:
- HADDR0, HADDR1, HWDATA0, HWDATA1 and HWRITEREG go to 0.
- The error FSM goes to OK.
REQ-032 During and immediately after reset, the outputs SHALL be: VALID=0 (HTRANS is ignored while reset is high), HRESP=00, HREADYout=HREADOUT.
REQ-033 A reset asserted in ERR1 or ERR2 SHALL abort the error response; the next cycle shows HRESP=00.

Structure
REQ-034 The following SHALL reside in a shared package bridge_pkg:
- Slave address-range constants.
- HTRANS and HRESP encodings.
- The error-FSM state typedef.
REQ-035 The address decoder SHALL be a separate sub-module, ahb_addr_decode (HADDR→TEMP); all other logic is flat.

Verification
REQ-036 The bench SHALL cover at least these directed scenarios:
- Reset: hold HRESETn=1 for 2 cycles with HTRANS=10 → VALID=0, HRESP=00, all pipeline registers 0.
- Single write: HADDR=0x8000_0010, HWRITE=1, HTRANS=10, HREADYin=1 → VALID=1, TEMP=001; next edge HADDR0=0x8000_0010, HWRITEREG=1.
- Burst: 0x8400_0000 then 0x8400_0004 (NONSEQ, SEQ) → VALID high for 2 cycles; afterwards HADDR1=0x8400_0000, HADDR0=0x8400_0004.
- Unmapped: HADDR=0x9000_0000, HTRANS=10 → VALID=0; then HREADYout=0/HRESP=01, then HREADYout=1/HRESP=01, then HRESP=00.
- Stall: HREADYin=0 for 3 cycles with HADDR changing → HADDR0 and HADDR1 unchanged, VALID=0.
- Reset in ERR1: drive HRESETn=1 in ERR1 → next cycle HRESP=00, HREADYout=HREADOUT.
